// File: rtl/tdm_tustin_lpf.sv
// tdm_tustin_lpf: first-order Tustin low-pass filter over a time-division
// multiplexed stream of FACTOR interleaved channels.
// Each channel keeps its own state. Outputs come out in input channel order,
// two cycles after the matching input.
// Input handshake: in_valid alone qualifies a sample. There is no ready, so a
// sample is taken in every cycle where in_valid=1 and clear=0.
// Output handshake: out_valid is a one-cycle strobe for each result. out and
// out_ch keep their values between strobes.
module tdm_tustin_lpf #(
    parameter int FACTOR  = 2,
    parameter int IN_W    = 27,
    parameter int ALPHA_W = 27,
    parameter int OUT_W   = 32,
    localparam int CW     = (FACTOR > 1) ? $clog2(FACTOR) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic signed [IN_W-1:0]    in,
    input  logic                      in_valid,
    input  logic        [ALPHA_W-1:0] alpha,
    output logic signed [OUT_W-1:0]   out,
    output logic                      out_valid,
    output logic        [CW-1:0]      out_ch
);

    // The accumulator has ALPHA_W fraction bits. u needs one more bit than the
    // accumulator, and the product needs room for u times the unsigned alpha.
    localparam int YW = IN_W + ALPHA_W + 1;
    localparam int UW = YW + 1;
    localparam int PW = UW + ALPHA_W + 1;
    // The state tables cover the full counter range, so any index is legal.
    localparam int NS = 1 << CW;

    logic        [CW-1:0]      ch_cnt;
    logic signed [IN_W-1:0]    x_prev [NS];
    logic signed [YW-1:0]      y_acc  [NS];

    logic                      s1_valid;
    logic        [CW-1:0]      s1_ch;
    logic        [ALPHA_W-1:0] s1_alpha;
    logic signed [UW-1:0]      s1_u;
    logic signed [IN_W-1:0]    s1_x;
    logic signed [YW-1:0]      s1_yb;

    logic                      fwd;
    logic signed [IN_W-1:0]    xp_cur;
    logic signed [YW-1:0]      y_cur;
    logic signed [IN_W:0]      sum;
    logic signed [UW-1:0]      sum_ext;
    logic signed [UW-1:0]      u_nxt;
    logic signed [PW-1:0]      u_ext;
    logic signed [PW-1:0]      a_ext;
    logic signed [PW-1:0]      prod;
    logic signed [YW-1:0]      y_new;
    logic signed [OUT_W-1:0]   out_nxt;

    // If stage 2 holds the same channel, its state write has not landed yet.
    // In that case stage 1 takes the forwarded values instead.
    assign fwd = s1_valid && (s1_ch == ch_cnt);

    // Stage-1 operand select with forwarding, then u = ((x + x_prev) << (A-1)) - y
    always_comb begin
        xp_cur = x_prev[ch_cnt];
        y_cur  = y_acc[ch_cnt];
        if (fwd) begin
            xp_cur = s1_x;
            y_cur  = y_new;
        end
        sum     = {in[IN_W-1], in} + {xp_cur[IN_W-1], xp_cur};
        sum_ext = {{(UW-IN_W-1){sum[IN_W]}}, sum};
        u_nxt   = (sum_ext <<< (ALPHA_W-1)) - {y_cur[YW-1], y_cur};
    end

    // Stage-2 update: y_new = y + floor(u * alpha / 2^ALPHA_W)
    assign u_ext   = {{(PW-UW){s1_u[UW-1]}}, s1_u};
    assign a_ext   = {{(PW-ALPHA_W){1'b0}}, s1_alpha};
    assign prod    = u_ext * a_ext;
    assign y_new   = s1_yb + YW'(prod >>> ALPHA_W);
    assign out_nxt = OUT_W'(y_new >>> ALPHA_W);

    // Channel counter: advances on each accepted sample and returns to 0 on clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_cnt <= '0;
        end else if (clear) begin
            ch_cnt <= '0;
        end else if (in_valid) begin
            if (ch_cnt == CW'(FACTOR-1)) ch_cnt <= '0;
            else                         ch_cnt <= ch_cnt + 1'b1;
        end
    end

    // Stage 1: register u together with the operands stage 2 needs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_alpha <= '0;
            s1_u     <= '0;
            s1_x     <= '0;
            s1_yb    <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ch    <= ch_cnt;
                s1_alpha <= alpha;
                s1_u     <= u_nxt;
                s1_x     <= in;
                s1_yb    <= y_cur;
            end
        end
    end

    // Stage 2: register the output and write the channel state back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            for (int i = 0; i < NS; i++) begin
                x_prev[i] <= '0;
                y_acc[i]  <= '0;
            end
        end else if (clear) begin
            out_valid <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                x_prev[i] <= '0;
                y_acc[i]  <= '0;
            end
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out           <= out_nxt;
                out_ch        <= s1_ch;
                x_prev[s1_ch] <= s1_x;
                y_acc[s1_ch]  <= y_new;
            end
        end
    end

endmodule
